// File: rtl/mmio_char_out_buffer.sv
// mmio_char_out_buffer: memory-mapped character output FIFO.
// The CPU stores bytes to DATA; an external consumer drains them through the
// first-word-fall-through io_output_* interface.
// Optional build macro: MMIO_OUT_DROP_COUNT_EN adds a saturating 16-bit
// dropped-push counter readable at DROPCNT.
module mmio_char_out_buffer #(
  parameter int unsigned BUFFER_DEPTH   = 16,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  input  logic        io_output_en,
  output logic [7:0]  io_output_data,
  output logic [31:0] io_buffer_size_avai
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUFFER_DEPTH);

  logic [7:0]    mem [BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          primed;

  logic [31:0] offset;
  logic [1:0]  reg_sel;
  logic        full;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        drop;
  logic        status_clr;
  logic [31:0] status_word;
  logic [31:0] dropcnt_word;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign offset   = addr - MMIO_BASE_ADDR;
  assign hit      = en && (offset[31:4] == '0);
  assign reg_sel  = addr[3:2];
  assign full     = (count == DEPTH_C);
  assign push_req = hit && (reg_sel == 2'd0) && we[0];
  assign pop      = io_output_en && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign status_clr = hit && (reg_sel == 2'd1) && we[3] && din[31];

  assign status_word = {overflow, 7'b0, 8'(count), 8'b0, 8'(DEPTH_C - count)};
  assign io_buffer_size_avai = 32'(count);
  // Output gated to zero until the first push after reset (array is not reset).
  assign io_output_data = primed ? mem[rd_ptr] : 8'h00;
  assign unused_bits = ^{din[30:8], offset[3:0]};

`ifdef MMIO_OUT_DROP_COUNT_EN
  logic [15:0] drop_cnt;
  logic        dropcnt_clr;

  assign dropcnt_clr  = hit && (reg_sel == 2'd2) && we[0];
  assign dropcnt_word = {16'b0, drop_cnt};

  // Saturating drop counter; an increment beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end else if (dropcnt_clr) begin
      drop_cnt <= '0;
    end
  end
`else
  assign dropcnt_word = '0;
`endif

  // Register read mux.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      2'd1:    rd_word = status_word;
      2'd2:    rd_word = dropcnt_word;
      default: rd_word = '0;
    endcase
  end

  // FIFO storage write port (contents intentionally not reset).
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din[7:0];
  end

  // Pointers, occupancy, sticky overflow and output gating flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      primed   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        primed <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
    end
  end

  // Registered read data; holds when not reading, like the RAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout <= '0;
    else if (en && hit && (we == 4'b0000)) dout <= rd_word;
  end

endmodule

// File: tb/tb_mmio_char_out_buffer.sv
// Directed self-checking bench for mmio_char_out_buffer.
module tb_mmio_char_out_buffer;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'b0000;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        hit;
  logic        io_output_en = 1'b0;
  logic [7:0]  io_output_data;
  logic [31:0] io_buffer_size_avai;

  int compared = 0;
  int mismatched = 0;

  mmio_char_out_buffer #(.BUFFER_DEPTH(16), .MMIO_BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout), .hit(hit), .io_output_en(io_output_en),
    .io_output_data(io_output_data), .io_buffer_size_avai(io_buffer_size_avai)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    en = 1'b1; we = 4'b0001; addr = BASE; din = {24'h0, b};
    step();
    en = 1'b0; we = 4'b0000;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [31:0] data);
    en = 1'b1; we = 4'b0000; addr = BASE + {28'h0, idx, 2'b00};
    step();
    en = 1'b0;
    data = dout;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    step();
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL reset_size got=%h exp=0", io_buffer_size_avai); end
    compared++; if (io_output_data !== 8'h00) begin mismatched++; $display("FAIL reset_data got=%h exp=00", io_output_data); end
    compared++; if (dout !== 32'h0) begin mismatched++; $display("FAIL reset_dout got=%h exp=0", dout); end
    compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL reset_hit got=%b exp=0", hit); end
  endtask

  task automatic test_hit_decode();
    en = 1'b1; we = 4'b0000;
    addr = BASE + 32'd15; #1;
    compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL hit_top got=%b exp=1", hit); end
    addr = BASE + 32'd16; #1;
    compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL hit_above got=%b exp=0", hit); end
    addr = BASE - 32'd1; #1;
    compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL hit_below got=%b exp=0", hit); end
    en = 1'b0; addr = BASE; #1;
    compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL hit_no_en got=%b exp=0", hit); end
  endtask

  task automatic test_basic();
    // Write to DATA without we[0] must not push.
    en = 1'b1; we = 4'b0010; addr = BASE; din = 32'h0000_4444;
    step();
    en = 1'b0; we = 4'b0000;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL no_we0_push got=%0d exp=0", io_buffer_size_avai); end
    push(8'h48);
    push(8'h69);
    compared++; if (io_buffer_size_avai !== 32'd2) begin mismatched++; $display("FAIL basic_size got=%0d exp=2", io_buffer_size_avai); end
    compared++; if (io_output_data !== 8'h48) begin mismatched++; $display("FAIL basic_head got=%h exp=48", io_output_data); end
    io_output_en = 1'b1;
    #1;
    compared++; if (io_output_data !== 8'h48) begin mismatched++; $display("FAIL basic_pop0 got=%h exp=48", io_output_data); end
    step();
    compared++; if (io_output_data !== 8'h69) begin mismatched++; $display("FAIL basic_pop1 got=%h exp=69", io_output_data); end
    compared++; if (io_buffer_size_avai !== 32'd1) begin mismatched++; $display("FAIL basic_size1 got=%0d exp=1", io_buffer_size_avai); end
    step();
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL basic_size0 got=%0d exp=0", io_buffer_size_avai); end
    step();
    io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL pop_empty_size got=%0d exp=0", io_buffer_size_avai); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    for (int i = 0; i < 16; i++) push(8'(i));
    compared++; if (io_buffer_size_avai !== 32'd16) begin mismatched++; $display("FAIL fill_size got=%0d exp=16", io_buffer_size_avai); end
    push(8'hAA);
    compared++; if (io_buffer_size_avai !== 32'd16) begin mismatched++; $display("FAIL drop_size got=%0d exp=16", io_buffer_size_avai); end
    compared++; if (io_output_data !== 8'h00) begin mismatched++; $display("FAIL drop_head got=%h exp=00", io_output_data); end
    read_reg(2'd1, r);
    compared++; if (r !== 32'h8010_0000) begin mismatched++; $display("FAIL status_ovf got=%h exp=80100000", r); end
    read_reg(2'd2, r);
`ifdef MMIO_OUT_DROP_COUNT_EN
    compared++; if (r !== 32'h0000_0001) begin mismatched++; $display("FAIL dropcnt got=%h exp=00000001", r); end
`else
    compared++; if (r !== 32'h0000_0000) begin mismatched++; $display("FAIL dropcnt got=%h exp=00000000", r); end
`endif
    read_reg(2'd3, r);
    compared++; if (r !== 32'h0) begin mismatched++; $display("FAIL reserved got=%h exp=0", r); end
    en = 1'b1; we = 4'b1000; addr = BASE + 32'd4; din = 32'h8000_0000;
    step();
    en = 1'b0; we = 4'b0000;
    read_reg(2'd1, r);
    compared++; if (r !== 32'h0010_0000) begin mismatched++; $display("FAIL status_clr got=%h exp=00100000", r); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] r;
    en = 1'b1; we = 4'b0001; addr = BASE; din = 32'h0000_0055;
    io_output_en = 1'b1;
    #1;
    compared++; if (io_output_data !== 8'h00) begin mismatched++; $display("FAIL fpp_head got=%h exp=00", io_output_data); end
    step();
    en = 1'b0; we = 4'b0000; io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd16) begin mismatched++; $display("FAIL fpp_size got=%0d exp=16", io_buffer_size_avai); end
    read_reg(2'd1, r);
    compared++; if (r !== 32'h0010_0000) begin mismatched++; $display("FAIL fpp_status got=%h exp=00100000", r); end
    io_output_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 16) ? 8'h55 : 8'(i);
      #1;
      compared++; if (io_output_data !== exp_b) begin mismatched++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, io_output_data, exp_b); end
      step();
    end
    io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL fpp_empty got=%0d exp=0", io_buffer_size_avai); end
  endtask

  task automatic test_empty_push_pop();
    en = 1'b1; we = 4'b0001; addr = BASE; din = 32'h0000_0033;
    io_output_en = 1'b1;
    step();
    en = 1'b0; we = 4'b0000; io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd1) begin mismatched++; $display("FAIL epp_size got=%0d exp=1", io_buffer_size_avai); end
    compared++; if (io_output_data !== 8'h33) begin mismatched++; $display("FAIL epp_head got=%h exp=33", io_output_data); end
    io_output_en = 1'b1;
    step();
    io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL epp_drain got=%0d exp=0", io_buffer_size_avai); end
  endtask

  task automatic test_back_to_back();
    io_output_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; we = 4'b0001; addr = BASE; din = {24'h0, 8'(i * 7 + 3)};
      #1;
      if (i > 0) begin
        compared++; if (io_output_data !== 8'((i - 1) * 7 + 3)) begin mismatched++; $display("FAIL stream[%0d] got=%h exp=%h", i - 1, io_output_data, 8'((i - 1) * 7 + 3)); end
        compared++; if (io_buffer_size_avai !== 32'd1) begin mismatched++; $display("FAIL stream_size[%0d] got=%0d exp=1", i, io_buffer_size_avai); end
      end
      step();
    end
    en = 1'b0; we = 4'b0000;
    #1;
    compared++; if (io_output_data !== 8'(39 * 7 + 3)) begin mismatched++; $display("FAIL stream[39] got=%h exp=%h", io_output_data, 8'(39 * 7 + 3)); end
    step();
    io_output_en = 1'b0;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL stream_end got=%0d exp=0", io_buffer_size_avai); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    read_reg(2'd1, r);
    compared++; if (r !== 32'h0005_000B) begin mismatched++; $display("FAIL pre_reset_status got=%h exp=0005000B", r); end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (io_buffer_size_avai !== 32'd0) begin mismatched++; $display("FAIL mid_reset_size got=%0d exp=0", io_buffer_size_avai); end
    compared++; if (dout !== 32'h0) begin mismatched++; $display("FAIL mid_reset_dout got=%h exp=0", dout); end
    compared++; if (io_output_data !== 8'h00) begin mismatched++; $display("FAIL mid_reset_data got=%h exp=00", io_output_data); end
    #3;
    reset = 1'b0;
    step();
    push(8'h7E);
    compared++; if (io_output_data !== 8'h7E) begin mismatched++; $display("FAIL post_reset_head got=%h exp=7E", io_output_data); end
    compared++; if (io_buffer_size_avai !== 32'd1) begin mismatched++; $display("FAIL post_reset_size got=%0d exp=1", io_buffer_size_avai); end
  endtask

  initial begin
    test_reset();
    test_hit_decode();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
